// File: rtl/d_flip_flop_edge_trig_if.sv
// Data/control bundle for d_flip_flop_edge_trig.
// The master side drives E/D (and SE/SI when DFF_SCAN_EN is defined) and
// observes Q/Qn (and SO). Clock and reset stay plain ports on the register.
interface d_flip_flop_edge_trig_if #(
    parameter int WIDTH = 1
);
    logic             E;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;
`ifdef DFF_SCAN_EN
    logic             SE;
    logic             SI;
    logic             SO;

    modport master (output E, D, SE, SI, input Q, Qn, SO);
    modport slave  (input E, D, SE, SI, output Q, Qn, SO);
`else
    modport master (output E, D, input Q, Qn);
    modport slave  (input E, D, output Q, Qn);
`endif
endinterface

// File: rtl/d_flip_flop_edge_trig.sv
// Positive-edge D register bank with true and complementary outputs.
// Priority on each rising C edge: R (load RESET_VAL) > SE (scan shift,
// only when DFF_SCAN_EN is defined) > E (capture D) > hold.
// Qn is derived from the same register so Q and Qn can never disagree.
// Optional feature macro: DFF_SCAN_EN adds SE/SI/SO scan chain support.
module d_flip_flop_edge_trig #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      C,
    input  logic                      R,
    d_flip_flop_edge_trig_if.slave    bus
);

    // Reject a zero-width bank at elaboration time.
    generate
        if (WIDTH < 1) begin : g_width_check
            $error("d_flip_flop_edge_trig: WIDTH must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] q_r;

`ifdef DFF_SCAN_EN
    logic [WIDTH-1:0] shift_next;

    // Scan shift toward the MSB: SI enters bit 0, each bit takes its lower neighbour.
    always_comb begin
        shift_next    = '0;
        shift_next[0] = bus.SI;
        for (int i = 1; i < WIDTH; i++) begin
            shift_next[i] = q_r[i-1];
        end
    end

    // Storage register: reset, then scan shift, then enabled capture, else hold.
    always_ff @(posedge C) begin
        if (R) begin
            q_r <= RESET_VAL;
        end else if (bus.SE) begin
            q_r <= shift_next;
        end else if (bus.E) begin
            q_r <= bus.D;
        end
    end

    assign bus.SO = q_r[WIDTH-1];
`else
    // Storage register: reset, then enabled capture, else hold.
    always_ff @(posedge C) begin
        if (R) begin
            q_r <= RESET_VAL;
        end else if (bus.E) begin
            q_r <= bus.D;
        end
    end
`endif

    assign bus.Q  = q_r;
    assign bus.Qn = ~q_r;

endmodule

// File: tb/tb_d_flip_flop_edge_trig.sv
// Directed bench for d_flip_flop_edge_trig: a 1-bit instance (reset value 0)
// and a 4-bit instance (reset value 4'b1010) driven in lockstep. Expected
// register contents are pushed to a scoreboard when stimulus is applied and
// popped when the outputs are sampled.
module tb_d_flip_flop_edge_trig;

    localparam logic [3:0] RV4 = 4'b1010;

    logic C = 1'b0;
    logic R = 1'b0;

    d_flip_flop_edge_trig_if #(.WIDTH(1)) bus1 ();
    d_flip_flop_edge_trig_if #(.WIDTH(4)) bus4 ();

    d_flip_flop_edge_trig #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .C   (C),
        .R   (R),
        .bus (bus1.slave)
    );

    d_flip_flop_edge_trig #(.WIDTH(4), .RESET_VAL(RV4)) dut4 (
        .C   (C),
        .R   (R),
        .bus (bus4.slave)
    );

    typedef struct {
        string      tag;
        logic       q1;
        logic [3:0] q4;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic       m1;
    logic [3:0] m4;

    task automatic push(input string tag, input logic q1, input logic [3:0] q4);
        exp_t e;
        e.tag = tag;
        e.q1  = q1;
        e.q4  = q4;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: observed size=%0d expected >0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (bus1.Q === e.q1 && bus1.Qn === ~e.q1) else begin
                errors++;
                $error("FAIL %s w1: observed Q=%b Qn=%b expected Q=%b Qn=%b",
                       e.tag, bus1.Q, bus1.Qn, e.q1, ~e.q1);
            end
            checks++;
            assert (bus4.Q === e.q4 && bus4.Qn === ~e.q4) else begin
                errors++;
                $error("FAIL %s w4: observed Q=%b Qn=%b expected Q=%b Qn=%b",
                       e.tag, bus4.Q, bus4.Qn, e.q4, ~e.q4);
            end
`ifdef DFF_SCAN_EN
            checks++;
            assert (bus1.SO === e.q1 && bus4.SO === e.q4[3]) else begin
                errors++;
                $error("FAIL %s so: observed SO1=%b SO4=%b expected SO1=%b SO4=%b",
                       e.tag, bus1.SO, bus4.SO, e.q1, e.q4[3]);
            end
`endif
        end
    endtask

    task automatic set_in(input logic e, input logic d1, input logic [3:0] d4);
        bus1.E = e;
        bus4.E = e;
        bus1.D = d1;
        bus4.D = d4;
    endtask

    // Rising edge of C: model the expected capture, push it, then sample 1 ns later.
    task automatic rise(input string tag);
        if (R) begin
            m1 = 1'b0;
            m4 = RV4;
        end
`ifdef DFF_SCAN_EN
        else if (bus1.SE) begin
            m1 = bus1.SI;
            m4 = {m4[2:0], bus4.SI};
        end
`endif
        else if (bus1.E) begin
            m1 = bus1.D;
            m4 = bus4.D;
        end
        push(tag, m1, m4);
        #5 C = 1'b1;
        #1 check();
    endtask

    task automatic fall();
        #4 C = 1'b0;
        #1;
    endtask

    task automatic hold(input string tag);
        push(tag, m1, m4);
        check();
    endtask

    initial begin
`ifdef DFF_SCAN_EN
        bus1.SE = 1'b0; bus4.SE = 1'b0;
        bus1.SI = 1'b0; bus4.SI = 1'b0;
`endif
        m1 = 1'bx;
        m4 = 4'bxxxx;

        // 1: synchronous reset loads RESET_VAL; inputs change with C low -> no change
        R = 1'b1;
        set_in(1'b1, 1'b1, 4'b1111);
        rise("reset");
        fall();
        R = 1'b0;
        set_in(1'b1, 1'b0, 4'b0000);
        #10 hold("c_low_hold");

        // 2: capture on rising edge, then D changes while C is high
        set_in(1'b1, 1'b1, 4'b0110);
        rise("capture_one");
        set_in(1'b1, 1'b0, 4'b1001);
        #10 hold("c_high_hold");

        // 3: falling edge does not capture; next rising edge does
        fall();
        hold("falling_hold");
        rise("capture_zero");
        fall();

        // 4: E=0 holds across several edges while D toggles, then E=1 captures
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, i[0] ? 1'b0 : 1'b1, 4'(i * 5 + 3));
            rise("enable_low_hold");
            fall();
        end
        set_in(1'b1, 1'b1, 4'b0101);
        rise("enable_capture");
        fall();

        // 5: reset overrides enable/data on the same edge
        R = 1'b1;
        set_in(1'b1, 1'b1, 4'b0011);
        rise("reset_wins");
        fall();
        R = 1'b0;
        rise("recapture");
        fall();
        // reset pulse strictly between edges must be ignored
        set_in(1'b0, 1'b0, 4'b0000);
        #1 R = 1'b1;
        #2 R = 1'b0;
        hold("r_pulse_no_edge");
        rise("r_pulse_then_edge");
        fall();

        // Mixed random control/data, one check per edge
        for (int i = 0; i < 10; i++) begin
            R = ($urandom_range(0, 5) == 0);
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)));
            rise("random");
            fall();
        end
        R = 1'b0;

`ifdef DFF_SCAN_EN
        // 6: clear, then shift SI=1,0,1,1 into bit 0 with E ignored
        set_in(1'b1, 1'b0, 4'b0000);
        rise("scan_clear");
        fall();
        set_in(1'b1, 1'b1, 4'b1111);
        bus1.SE = 1'b1;
        bus4.SE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus1.SI = (i != 1);
            bus4.SI = (i != 1);
            rise("scan_shift");
            fall();
        end
        checks++;
        assert (bus4.Q === 4'b1011 && bus4.SO === 1'b1) else begin
            errors++;
            $error("FAIL scan_result: observed Q=%b SO=%b expected Q=1011 SO=1",
                   bus4.Q, bus4.SO);
        end
        // SE=0 returns to normal D capture
        bus1.SE = 1'b0;
        bus4.SE = 1'b0;
        set_in(1'b1, 1'b0, 4'b0110);
        rise("scan_off_capture");
        fall();
`endif

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed size=%0d expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
